// File: rtl/serial_compare_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_compare_ctrl_if
// Request/result bundle between a requesting master and serial_compare_ctrl.
//
// Signals:
//   start  master -> slave  request, sampled only while busy=0
//   a, b   master -> slave  WIDTH-bit unsigned operands, captured with start
//   busy   slave  -> master comparison in progress
//   done   slave  -> master one-cycle pulse, lt/eq/gt freshly updated
//   lt/eq/gt slave -> master registered result, held until the next done
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0 (the controller is idle or in its done cycle); a and b are captured
// on that same edge. start while busy=1 is ignored. Exactly one done pulse
// follows each accepted request unless reset intervenes.
// -----------------------------------------------------------------------------
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, a, b,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, a, b,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// serial_compare_ctrl
// Compares two WIDTH-bit unsigned operands one 2-bit digit per cycle (MSB
// digit first) through a single 2-bit combinational comparator, stopping at
// the first unequal digit. Result is registered and reported with done.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        serial_compare_ctrl_if.slave (start/a/b in, busy/done/lt/eq/gt out)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------

// 2-bit unsigned magnitude comparator, purely combinational.
module comparator_2bit (
  input  logic A1,
  input  logic A0,
  input  logic B1,
  input  logic B0,
  output logic lt,
  output logic gt,
  output logic eq
);
  assign lt = ({A1, A0} <  {B1, B0});
  assign gt = ({A1, A0} >  {B1, B0});
  assign eq = ({A1, A0} == {B1, B0});
endmodule

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_compare_ctrl_if.slave  bus,
  output logic [1:0]            dbg_state
);
  localparam int NDIG = WIDTH / 2;
  localparam int CW   = $clog2(NDIG + 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_compare_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic c_lt, c_gt, c_eq;

  // Comparator sees the current top digit directly; decision logic uses its
  // outputs in the same cycle.
  comparator_2bit u_cmp (
    .A1 (sa_q[WIDTH-1]),
    .A0 (sa_q[WIDTH-2]),
    .B1 (sb_q[WIDTH-1]),
    .B0 (sb_q[WIDTH-2]),
    .lt (c_lt),
    .gt (c_gt),
    .eq (c_eq)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts start just like IDLE so requests can run back to back.
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cnt_d   = CW'(NDIG);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (c_lt || c_gt) begin
          lt_d    = c_lt;
          gt_d    = c_gt;
          eq_d    = 1'b0;
          state_d = S_DONE;
        end else if (c_eq) begin
          if (cnt_q == CW'(1)) begin
            lt_d    = 1'b0;
            gt_d    = 1'b0;
            eq_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            sa_d  = {sa_q[WIDTH-3:0], 2'b00};
            sb_d  = {sb_q[WIDTH-3:0], 2'b00};
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy  = (state_q == S_RUN);
    bus.done  = (state_q == S_DONE);
    bus.lt    = lt_q;
    bus.eq    = eq_q;
    bus.gt    = gt_q;
    dbg_state = state_q;
  end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
module tb_serial_compare_ctrl;
  localparam int WIDTH = 8;
  localparam int NDIG  = WIDTH / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus_if ();
  logic [1:0] dbg_state;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [2:0] last_res = 3'b000;      // {lt,eq,gt}
  logic [34:0] exp_q[$];              // {done cycle, lt, eq, gt}
  logic [34:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a < b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int d = 1; d <= NDIG; d++)
      if (a[WIDTH-2*d +: 2] != b[WIDTH-2*d +: 2]) return d;
    return NDIG;
  endfunction

  // ---------------- driver tasks ----------------
  // Present inputs, then advance past the next rising edge.
  task automatic drive(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus_if.start = s;
    bus_if.a = a;
    bus_if.b = b;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that accepted (a,b).
  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [31:0] c;
    c = 32'(cyc + model_lat(a, b));
    exp_q.push_back({c, model_res(a, b)});
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_done", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    drive(1'b1, a, b);
    push_exp(a, b);
    bus_if.start = 1'b0;
    wait_empty();
    drive(1'b0, '0, '0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus_if.busy), 0);
    check({tag, "_done"}, 32'(bus_if.done), 0);
    check({tag, "_res"}, 32'({bus_if.lt, bus_if.eq, bus_if.gt}), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_if.done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", 32'({bus_if.lt, bus_if.eq, bus_if.gt}), 32'(mon_e[2:0]));
          check("latency", 32'(cyc), mon_e[34:3]);
          last_res = mon_e[2:0];
        end
      end else begin
        check("hold", 32'({bus_if.lt, bus_if.eq, bus_if.gt}), 32'(last_res));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] ra, rb;
    bus_if.start = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;

    // 1: reset, then idle with start=0
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_res = 3'b000;
    mon_en = 1'b1;
    check_idle("reset");
    repeat (3) drive(1'b0, '0, '0);
    check_idle("idle");

    // 2: equal operands, busy for all 4 digits
    drive(1'b1, 8'hA5, 8'hA5);
    push_exp(8'hA5, 8'hA5);
    bus_if.start = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      check("busy_run", 32'(bus_if.busy), 1);
      @(posedge clk);
      #1;
    end
    check("busy_done", 32'(bus_if.busy), 0);
    wait_empty();
    drive(1'b0, '0, '0);

    // 3: MSB-digit early exit both ways
    run_op(8'h80, 8'h40);
    run_op(8'h40, 8'h80);

    // 4: decided on last digit
    run_op(8'h13, 8'h12);
    run_op(8'h12, 8'h13);

    // 5: start while busy ignored, start during DONE accepted
    drive(1'b1, 8'h00, 8'hFF);
    push_exp(8'h00, 8'hFF);
    drive(1'b1, 8'hFF, 8'h00);   // edge lands while RUN
    check("done_cycle", 32'(bus_if.done), 1);
    drive(1'b1, 8'h3C, 8'h3C);   // edge lands in DONE
    push_exp(8'h3C, 8'h3C);
    bus_if.start = 1'b0;
    check("b2b_busy", 32'(bus_if.busy), 1);
    wait_empty();
    drive(1'b0, '0, '0);

    // 6: reset during second RUN cycle aborts
    drive(1'b1, 8'h0F, 8'h0E);
    bus_if.start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_res = 3'b000;
    check_idle("abort");
    repeat (6) drive(1'b0, '0, '0);
    check_idle("abort_quiet");
    run_op(8'h0F, 8'h0E);

    // random operations, some with equal operands
    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom_range(0, 255));
      run_op(ra, rb);
    end

    repeat (2) drive(1'b0, '0, '0);
    check("final_queue", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
Sequencing controller that compares two WIDTH-bit unsigned operands with the team's existing 2-bit combinational comparator. Ports of that comparator: A1, A0, B1, B0, lt, gt, eq. The controller feeds it one 2-bit digit per cycle, MSB digit first, and stops early at the first unequal digit. It registers the final lt/eq/gt result and reports it with a start/done handshake. It sits between a requesting master and the single shared comparator instance.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (elaboration error otherwise).
NDIG, WIDTH/2, number of 2-bit digits (derived; not overridable).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  operand A; sampled on the edge that accepts start.
b  input  WIDTH  operand B; sampled on the edge that accepts start.
busy  output  1  high while a comparison is in progress (state RUN).
done  output  1  one-cycle pulse; lt/eq/gt are valid and newly updated.
lt  output  1  registered result: A < B.
eq  output  1  registered result: A == B.
gt  output  1  registered result: A > B.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free; only the behaviour below is required.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE.
  - busy, done, lt, eq and gt all go to 0.
  - Operand shift registers and digit counter are cleared.
  - Reset has priority over all other inputs.
- IDLE, start=1:
  - Load a and b into shift registers sa and sb.
  - Set digit counter to NDIG.
  - Go to RUN; busy=1 from the next cycle.
- IDLE or DONE, start=0: go to (or remain in) IDLE.
- DONE, start=1: accepted exactly as from IDLE, so back-to-back operations need no idle gap.
- RUN, start=1: ignored; operand registers are not disturbed.
- RUN, comparator wiring:
  - A1/A0 are driven from sa[WIDTH-1:WIDTH-2].
  - B1/B0 are driven from sb[WIDTH-1:WIDTH-2].
- RUN, each clock edge:
  - Comparator lt=1 or gt=1: register lt/gt from the comparator, set eq=0, go to DONE. This is the early exit.
  - Comparator eq=1 and counter==1: register eq=1, lt=0, gt=0, go to DONE.
  - Comparator eq=1 and counter>1: shift sa and sb left by 2 (zero fill), decrement counter, stay in RUN.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next state is RUN if start=1, otherwise IDLE.
- Latency: start is accepted at edge E0. If the deciding digit is digit k (k=1 is the MSB digit), done is high in the cycle following edge E0+k. Range is 1 to NDIG cycles.
- lt/eq/gt hold their value from the most recent done until the next done or reset. They do not change when start is accepted.
- Exactly one of lt/eq/gt is high after any completed comparison; all three are 0 only after reset.
- Reset mid-RUN aborts the operation: no done pulse, and outputs are cleared per the reset rule.
- The comparator is purely combinational; the controller must not add a register stage between comparator output and decision logic.
- Operands are unsigned; there is no signed mode.

Test Plan:
1. Hold rst_n=0 for 2 cycles, then release -> busy=done=lt=eq=gt=0; start=0 keeps all outputs at 0.
2. WIDTH=8, a=8'hA5, b=8'hA5, start pulse -> busy high for 4 cycles; done pulses in the 4th cycle after acceptance with eq=1, lt=0, gt=0.
3. a=8'h80, b=8'h40 -> first digit 10 vs 01; done 1 cycle after acceptance with gt=1. Then a=8'h40, b=8'h80 -> lt=1 after 1 cycle.
4. a=8'h13, b=8'h12 -> digits equal until digit 4 (11 vs 10); done after 4 cycles with gt=1. Swapped operands -> lt=1 after 4 cycles.
5. Start a=8'h00, b=8'hFF, then assert start with a=8'hFF, b=8'h00 in the next cycle while busy -> second request ignored; result lt=1 after 1 cycle. Assert start during the DONE cycle with a=b=8'h3C -> accepted with no idle cycle; eq=1 after 4 more cycles.
6. Start a=8'h0F, b=8'h0E and drive rst_n=0 on the 2nd RUN cycle -> no done pulse; all outputs 0; state IDLE. A fresh start afterwards completes normally (gt=1 after 4 cycles).
